// File: rtl/alu_rs.sv
// alu_rs: reservation station that buffers ALU/branch/jump instructions until
// both operands are known and dispatches at most one ready entry per cycle.
//   clk, rst (async, active-high), rdy (global enable), rollback (flush)
//   issue_*     : decoded instruction from issue, with per-operand ready/value/tag
//   full        : every entry busy (combinational from busy flags)
//   alu_res_*   : ALU result broadcast snooped for operand wakeup
//   lsb_res_*   : LSB result broadcast snooped for operand wakeup
//   alu_en, opcode, funct3, funct7, val1, val2, imm, pc, rob_pos : registered dispatch port
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             issue_en,
    input  logic [6:0]       issue_opcode,
    input  logic [2:0]       issue_funct3,
    input  logic             issue_funct7,
    input  logic             issue_rdy1,
    input  logic             issue_rdy2,
    input  logic [31:0]      issue_val1,
    input  logic [31:0]      issue_val2,
    input  logic [ROB_W-1:0] issue_tag1,
    input  logic [ROB_W-1:0] issue_tag2,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_rob_pos,
    output logic             full,
    input  logic             alu_res,
    input  logic [ROB_W-1:0] alu_res_rob_pos,
    input  logic [31:0]      alu_res_val,
    input  logic             lsb_res,
    input  logic [ROB_W-1:0] lsb_res_rob_pos,
    input  logic [31:0]      lsb_res_val,
    output logic             alu_en,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic             funct7,
    output logic [31:0]      val1,
    output logic [31:0]      val2,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [ROB_W-1:0] rob_pos
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy, ok1, ok2, e_funct7;
    logic [6:0]         e_opcode [RS_SIZE];
    logic [2:0]         e_funct3 [RS_SIZE];
    logic [31:0]        e_val1   [RS_SIZE];
    logic [31:0]        e_val2   [RS_SIZE];
    logic [31:0]        e_imm    [RS_SIZE];
    logic [31:0]        e_pc     [RS_SIZE];
    logic [ROB_W-1:0]   e_tag1   [RS_SIZE];
    logic [ROB_W-1:0]   e_tag2   [RS_SIZE];
    logic [ROB_W-1:0]   e_rob    [RS_SIZE];
    logic [IW-1:0]      free_idx, sel_idx;
    logic               any_ready;

    assign full = &busy;

    // Lowest-index free slot and lowest-index ready entry, both from pre-edge state.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        any_ready = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IW'(i);
            if (busy[i] && ok1[i] && ok2[i]) begin
                sel_idx   = IW'(i);
                any_ready = 1'b1;
            end
        end
    end

    // Resolve one operand against the broadcasts; ALU takes precedence over LSB.
    function automatic logic [32:0] snoop(input logic ok, input logic [31:0] v,
                                          input logic [ROB_W-1:0] t);
        if (ok) return {1'b1, v};
        if (alu_res && alu_res_rob_pos == t) return {1'b1, alu_res_val};
        if (lsb_res && lsb_res_rob_pos == t) return {1'b1, lsb_res_val};
        return {1'b0, v};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            ok1      <= '0;
            ok2      <= '0;
            e_funct7 <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_opcode[i] <= '0;
                e_funct3[i] <= '0;
                e_val1[i]   <= '0;
                e_val2[i]   <= '0;
                e_imm[i]    <= '0;
                e_pc[i]     <= '0;
                e_tag1[i]   <= '0;
                e_tag2[i]   <= '0;
                e_rob[i]    <= '0;
            end
            alu_en  <= 1'b0;
            opcode  <= '0;
            funct3  <= '0;
            funct7  <= 1'b0;
            val1    <= '0;
            val2    <= '0;
            imm     <= '0;
            pc      <= '0;
            rob_pos <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy   <= '0;
                alu_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        {ok1[i], e_val1[i]} <= snoop(ok1[i], e_val1[i], e_tag1[i]);
                        {ok2[i], e_val2[i]} <= snoop(ok2[i], e_val2[i], e_tag2[i]);
                    end
                end
                alu_en <= any_ready;
                if (any_ready) begin
                    busy[sel_idx] <= 1'b0;
                    opcode  <= e_opcode[sel_idx];
                    funct3  <= e_funct3[sel_idx];
                    funct7  <= e_funct7[sel_idx];
                    val1    <= e_val1[sel_idx];
                    val2    <= e_val2[sel_idx];
                    imm     <= e_imm[sel_idx];
                    pc      <= e_pc[sel_idx];
                    rob_pos <= e_rob[sel_idx];
                end
                // free_idx is never busy, so it cannot collide with sel_idx or a wakeup.
                if (issue_en && !full) begin
                    busy[free_idx]     <= 1'b1;
                    e_opcode[free_idx] <= issue_opcode;
                    e_funct3[free_idx] <= issue_funct3;
                    e_funct7[free_idx] <= issue_funct7;
                    e_imm[free_idx]    <= issue_imm;
                    e_pc[free_idx]     <= issue_pc;
                    e_rob[free_idx]    <= issue_rob_pos;
                    e_tag1[free_idx]   <= issue_tag1;
                    e_tag2[free_idx]   <= issue_tag2;
                    {ok1[free_idx], e_val1[free_idx]} <= snoop(issue_rdy1, issue_val1, issue_tag1);
                    {ok2[free_idx], e_val2[free_idx]} <= snoop(issue_rdy2, issue_val2, issue_tag2);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs (vector table, directed sequences, random vs model).
module tb_alu_rs;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
    logic        issue_en, issue_funct7, issue_rdy1, issue_rdy2;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic [3:0]  issue_tag1, issue_tag2, issue_rob_pos;
    logic        full, alu_res, lsb_res;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        alu_en, funct7;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] val1, val2, imm, pc;
    logic [3:0]  rob_pos;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_en(issue_en), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
        .issue_funct7(issue_funct7), .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
        .issue_val1(issue_val1), .issue_val2(issue_val2), .issue_tag1(issue_tag1),
        .issue_tag2(issue_tag2), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rob_pos(issue_rob_pos), .full(full),
        .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .alu_en(alu_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .val1(val1), .val2(val2), .imm(imm), .pc(pc), .rob_pos(rob_pos)
    );

    // Reference model: a pool of 16 instruction slots plus the dispatch register.
    typedef struct {
        logic        busy, f7, ok1, ok2;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  t1, t2, rob;
    } ent_t;
    ent_t        m [16];
    logic        m_en, m_f7;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [31:0] m_v1, m_v2, m_imm, m_pc;
    logic [3:0]  m_rob;

    function automatic logic m_full();
        foreach (m[i]) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_reset();
        foreach (m[i]) m[i] = '{default: '0};
        m_en = 0; m_f7 = 0; m_op = 0; m_f3 = 0;
        m_v1 = 0; m_v2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
    endfunction

    // An operand value is known if it was ready, or its producer is on a bus now (ALU first).
    function automatic logic [32:0] known(input logic ok, input logic [31:0] v, input logic [3:0] t);
        if (ok) return {1'b1, v};
        if (alu_res && alu_res_rob_pos == t) return {1'b1, alu_res_val};
        if (lsb_res && lsb_res_rob_pos == t) return {1'b1, lsb_res_val};
        return {1'b0, v};
    endfunction

    function automatic void m_edge();
        ent_t pre [16];
        int   s, f;
        if (!rdy) return;
        if (rollback) begin
            foreach (m[i]) m[i].busy = 0;
            m_en = 0;
            return;
        end
        pre = m;
        s = -1;
        f = -1;
        for (int i = 0; i < 16; i++) begin
            if (s < 0 && pre[i].busy && pre[i].ok1 && pre[i].ok2) s = i;
            if (f < 0 && !pre[i].busy) f = i;
        end
        for (int i = 0; i < 16; i++)
            if (pre[i].busy) begin
                {m[i].ok1, m[i].v1} = known(pre[i].ok1, pre[i].v1, pre[i].t1);
                {m[i].ok2, m[i].v2} = known(pre[i].ok2, pre[i].v2, pre[i].t2);
            end
        m_en = (s >= 0);
        if (s >= 0) begin
            m_op = pre[s].op; m_f3 = pre[s].f3; m_f7 = pre[s].f7;
            m_v1 = pre[s].v1; m_v2 = pre[s].v2; m_imm = pre[s].imm;
            m_pc = pre[s].pc; m_rob = pre[s].rob;
            m[s].busy = 0;
        end
        if (issue_en && f >= 0) begin
            m[f].busy = 1; m[f].op = issue_opcode; m[f].f3 = issue_funct3; m[f].f7 = issue_funct7;
            m[f].imm = issue_imm; m[f].pc = issue_pc; m[f].rob = issue_rob_pos;
            m[f].t1 = issue_tag1; m[f].t2 = issue_tag2;
            {m[f].ok1, m[f].v1} = known(issue_rdy1, issue_val1, issue_tag1);
            {m[f].ok2, m[f].v2} = known(issue_rdy2, issue_val2, issue_tag2);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("m_alu_en", alu_en, m_en);
        chk("m_full", full, m_full());
        chk("m_opcode", opcode, m_op);
        chk("m_funct3", funct3, m_f3);
        chk("m_funct7", funct7, m_f7);
        chk("m_val1", val1, m_v1);
        chk("m_val2", val2, m_v2);
        chk("m_imm", imm, m_imm);
        chk("m_pc", pc, m_pc);
        chk("m_rob_pos", rob_pos, m_rob);
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
        cmp_model();
    endtask

    task automatic idle();
        issue_en = 0; issue_opcode = 0; issue_funct3 = 0; issue_funct7 = 0;
        issue_rdy1 = 0; issue_rdy2 = 0; issue_val1 = 0; issue_val2 = 0;
        issue_tag1 = 0; issue_tag2 = 0; issue_imm = 0; issue_pc = 0; issue_rob_pos = 0;
        alu_res = 0; alu_res_rob_pos = 0; alu_res_val = 0;
        lsb_res = 0; lsb_res_rob_pos = 0; lsb_res_val = 0;
        rollback = 0;
    endtask

    task automatic set_issue(input logic [3:0] rob, input logic r1, input logic [3:0] t1,
                             input logic [31:0] v1, input logic r2, input logic [3:0] t2,
                             input logic [31:0] v2);
        issue_en = 1; issue_opcode = 7'h33; issue_funct3 = 0; issue_funct7 = 0;
        issue_rdy1 = r1; issue_tag1 = t1; issue_val1 = v1;
        issue_rdy2 = r2; issue_tag2 = t2; issue_val2 = v2;
        issue_rob_pos = rob; issue_imm = 32'h10 + rob; issue_pc = 32'h1000 + 4 * rob;
    endtask

    task automatic flush();
        idle();
        rollback = 1;
        tick();
        rollback = 0;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, r1, r2;
        logic [31:0] v1, v2;
        logic [3:0]  t1, t2;
        logic [31:0] imm, pc;
        logic [3:0]  rob;
        logic        ab;
        logic [3:0]  at;
        logic [31:0] av;
        logic        lb;
        logic [3:0]  lt;
        logic [31:0] lv, e1, e2;
    } vec_t;
    vec_t vt [6];

    initial begin
        vt[0] = '{7'h13, 3'd0, 1'b0, 1'b1, 1'b1, 32'd5, 32'd0, 4'd0, 4'd0, 32'd3, 32'h1000, 4'd2,
                  1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd0};
        vt[1] = '{7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1, 4'd3, 4'd0, 32'd0, 32'h2000, 4'd7,
                  1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vt[2] = '{7'h63, 3'd1, 1'b0, 1'b0, 1'b1, 32'h55, 32'd9, 4'd6, 4'd0, 32'hFFFFFFF0, 32'h3000, 4'd1,
                  1'b1, 4'd6, 32'h111, 1'b1, 4'd6, 32'h222, 32'h111, 32'd9};
        vt[3] = '{7'h33, 3'd0, 1'b1, 1'b1, 1'b0, 32'hA, 32'd0, 4'd0, 4'd9, 32'd0, 32'h4000, 4'd4,
                  1'b1, 4'd9, 32'h77, 1'b1, 4'd2, 32'h99, 32'hA, 32'h77};
        vt[4] = '{7'h6F, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd12, 4'd13, 32'd8, 32'hFFFC, 4'd15,
                  1'b1, 4'd12, 32'h1234, 1'b1, 4'd13, 32'h5678, 32'h1234, 32'h5678};
        vt[5] = '{7'h33, 3'd7, 1'b0, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd0, 4'd0, 32'd0, 32'd4, 4'd0,
                  1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'hF0F0F0F0, 32'h0FF00FF0};

        idle();
        m_reset();
        #12 rst = 0;
        #1;
        cmp_model();
        chk("rst_alu_en", alu_en, 0);
        chk("rst_full", full, 0);

        // Single instruction, issued with any bypass broadcasts in the same cycle.
        foreach (vt[k]) begin
            flush();
            issue_en = 1; issue_opcode = vt[k].op; issue_funct3 = vt[k].f3; issue_funct7 = vt[k].f7;
            issue_rdy1 = vt[k].r1; issue_rdy2 = vt[k].r2; issue_val1 = vt[k].v1; issue_val2 = vt[k].v2;
            issue_tag1 = vt[k].t1; issue_tag2 = vt[k].t2; issue_imm = vt[k].imm; issue_pc = vt[k].pc;
            issue_rob_pos = vt[k].rob;
            alu_res = vt[k].ab; alu_res_rob_pos = vt[k].at; alu_res_val = vt[k].av;
            lsb_res = vt[k].lb; lsb_res_rob_pos = vt[k].lt; lsb_res_val = vt[k].lv;
            tick();
            chk("vec_issue_en", alu_en, 0);
            idle();
            tick();
            chk("vec_en", alu_en, 1);
            chk("vec_val1", val1, vt[k].e1);
            chk("vec_val2", val2, vt[k].e2);
            chk("vec_imm", imm, vt[k].imm);
            chk("vec_pc", pc, vt[k].pc);
            chk("vec_rob", rob_pos, vt[k].rob);
            chk("vec_op", {funct7, funct3, opcode}, {vt[k].f7, vt[k].f3, vt[k].op});
            tick();
            chk("vec_done", alu_en, 0);
        end

        // Wakeup by an ALU broadcast after issue.
        flush();
        set_issue(4'd1, 0, 4'd4, 0, 1, 4'd0, 32'd7);
        tick();
        idle();
        tick();
        chk("wake_wait", alu_en, 0);
        alu_res = 1; alu_res_rob_pos = 4; alu_res_val = 32'd10;
        tick();
        idle();
        chk("wake_lat", alu_en, 0);
        tick();
        chk("wake_en", alu_en, 1);
        chk("wake_val1", val1, 10);
        chk("wake_val2", val2, 7);

        // Fill every slot, drop an extra issue, then free slot 0.
        flush();
        for (int i = 0; i < 16; i++) begin
            set_issue(4'(i), 0, (i == 0) ? 4'd7 : 4'd9, 0, 1, 4'd0, 32'(i));
            tick();
        end
        idle();
        chk("fill_full", full, 1);
        set_issue(4'd15, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
        tick();
        idle();
        chk("drop_full", full, 1);
        chk("drop_en", alu_en, 0);
        alu_res = 1; alu_res_rob_pos = 7; alu_res_val = 32'h42;
        tick();
        idle();
        chk("full_wait", full, 1);
        tick();
        chk("full_disp_en", alu_en, 1);
        chk("full_disp_rob", rob_pos, 0);
        chk("full_disp_val1", val1, 32'h42);
        chk("full_clear", full, 0);
        tick();
        chk("drop_never", alu_en, 0);

        // Three entries woken together leave in index order.
        flush();
        for (int i = 0; i < 6; i++) begin
            set_issue(4'(i), 0, (i == 0 || i == 2 || i == 5) ? 4'd10 : 4'd11, 0, 1, 4'd0, 0);
            tick();
        end
        idle();
        alu_res = 1; alu_res_rob_pos = 10; alu_res_val = 32'd1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("order_en", alu_en, 1);
            chk("order_rob", rob_pos, (k == 0) ? 0 : (k == 1) ? 2 : 5);
        end
        tick();
        chk("order_end", alu_en, 0);

        // Rollback with six waiting entries and a dispatch in flight.
        for (int i = 6; i < 9; i++) begin
            set_issue(4'(i), 0, 4'd11, 0, 1, 4'd0, 0);
            tick();
        end
        set_issue(4'd12, 1, 4'd0, 32'd3, 1, 4'd0, 32'd4);
        tick();
        idle();
        tick();
        chk("rb_pre_en", alu_en, 1);
        chk("rb_pre_rob", rob_pos, 12);
        rollback = 1;
        tick();
        rollback = 0;
        chk("rb_en", alu_en, 0);
        chk("rb_full", full, 0);
        alu_res = 1; alu_res_rob_pos = 11; alu_res_val = 32'd5;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rb_none", alu_en, 0);
        end

        // rdy low freezes outputs and ignores issue.
        set_issue(4'd3, 1, 4'd0, 32'd30, 1, 4'd0, 32'd31);
        tick();
        set_issue(4'd5, 1, 4'd0, 32'd50, 1, 4'd0, 32'd51);
        tick();
        idle();
        chk("frz_pre", rob_pos, 3);
        rdy = 0;
        set_issue(4'd14, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("frz_en", alu_en, 1);
            chk("frz_rob", rob_pos, 3);
            chk("frz_val1", val1, 30);
        end
        idle();
        rdy = 1;
        tick();
        chk("frz_next", rob_pos, 5);
        tick();
        chk("frz_end", alu_en, 0);

        // Asynchronous reset between edges.
        set_issue(4'd9, 1, 4'd0, 32'd9, 1, 4'd0, 32'd9);
        tick();
        set_issue(4'd8, 0, 4'd2, 32'd0, 1, 4'd0, 32'd0);
        tick();
        idle();
        chk("arst_pre", alu_en, 1);
        #3 rst = 1;
        #1;
        chk("arst_en", alu_en, 0);
        chk("arst_full", full, 0);
        chk("arst_rob", rob_pos, 0);
        m_reset();
        #1 rst = 0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 15) != 0);
            rollback = ($urandom_range(0, 63) == 0);
            issue_en = $urandom_range(0, 1);
            issue_opcode = 7'($urandom); issue_funct3 = 3'($urandom); issue_funct7 = 1'($urandom);
            issue_rdy1 = $urandom_range(0, 1); issue_rdy2 = $urandom_range(0, 1);
            issue_val1 = $urandom; issue_val2 = $urandom;
            issue_tag1 = 4'($urandom); issue_tag2 = 4'($urandom);
            issue_imm = $urandom; issue_pc = $urandom; issue_rob_pos = 4'($urandom);
            alu_res = ($urandom_range(0, 2) == 0); alu_res_rob_pos = 4'($urandom); alu_res_val = $urandom;
            lsb_res = ($urandom_range(0, 2) == 0); lsb_res_rob_pos = 4'($urandom); lsb_res_val = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
